// File: rtl/led_pkg.sv
// Shared types and the pattern seed helper for the LED pattern generator.
package led_pkg;

    localparam int MAX_LEDS = 64;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SCAN  = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_HOLD  = 2'd3
    } led_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } led_dir_e;

    // Value loaded into the bank when a pattern is entered; HOLD keeps what is shown.
    function automatic logic [MAX_LEDS-1:0] led_seed(input led_mode_e m, input int n,
                                                     input logic [MAX_LEDS-1:0] cur);
        case (m)
            MODE_COUNT: led_seed = '0;
            MODE_SCAN:  led_seed = MAX_LEDS'(1);
            MODE_BLINK: led_seed = {MAX_LEDS{1'b1}} >> (MAX_LEDS - n);
            default:    led_seed = cur;
        endcase
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Divides hwclk by DIV; step is high on the last count of each enabled period.
module led_prescaler #(
    parameter int DIV = 12000000
) (
    input  logic hwclk,
    input  logic rst_n,
    input  logic en,
    output logic step
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] pcnt;

    assign step = en && (pcnt == LAST);

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= (pcnt == LAST) ? '0 : pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: steps COUNT/SCAN/BLINK/HOLD patterns at the prescaled tick rate.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int N_LEDS  = 8,
    parameter int CLK_HZ  = 12000000,
    parameter int TICK_HZ = 1
) (
    input  logic              hwclk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] leds,
    output logic              tick
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;

    led_mode_e         mode_in;
    led_mode_e         mode_q;
    led_dir_e          dir;
    logic              step;
    logic [N_LEDS-1:0] seed_val;
    logic [N_LEDS-1:0] scan_next;

    led_prescaler #(.DIV(TICK_DIV)) u_prescaler (
        .hwclk (hwclk),
        .rst_n (rst_n),
        .en    (en),
        .step  (step)
    );

    assign mode_in   = led_mode_e'(mode);
    assign seed_val  = N_LEDS'(led_seed(mode_in, N_LEDS, MAX_LEDS'(leds)));
    assign scan_next = (dir == DIR_UP) ? (leds << 1) : (leds >> 1);

    // NOTE: async reset in the sensitivity list and <= throughout, so every flop
    // samples pre-edge values and clears without waiting for hwclk.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            leds   <= '0;
            mode_q <= MODE_COUNT;
            dir    <= DIR_UP;
            tick   <= 1'b0;
        end else begin
            tick <= step;
            if (step) begin
                if (mode_in != mode_q) begin
                    // A mode switch spends its step loading the seed, not advancing.
                    mode_q <= mode_in;
                    leds   <= seed_val;
                    dir    <= DIR_UP;
                end else begin
                    case (mode_q)
                        MODE_COUNT: leds <= leds + 1'b1;
                        MODE_SCAN: begin
                            leds <= scan_next;
                            if (scan_next[N_LEDS-1])
                                dir <= DIR_DOWN;
                            else if (scan_next[0])
                                dir <= DIR_UP;
                        end
                        MODE_BLINK: leds <= ~leds;
                        MODE_HOLD:  leds <= leds;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized bench: three generator configurations against an arithmetic reference model.
module tb_led_pattern_gen;

    localparam int NDUT = 3;

    logic       hwclk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;

    logic [3:0] leds_a;
    logic [7:0] leds_b;
    logic [3:0] leds_c;
    logic       tick_a, tick_b, tick_c;

    int tests  = 0;
    int errors = 0;

    // Per-configuration model parameters: divide ratio and bank width.
    int m_div[NDUT] = '{4, 8, 1};
    int m_n[NDUT]   = '{4, 8, 4};

    // Model state: enabled edges since reset, shown pattern and scan phase.
    int m_ecnt[NDUT];
    int m_mode[NDUT];
    int m_leds[NDUT];
    int m_phase[NDUT];
    int m_tick[NDUT];

    always #5 hwclk = ~hwclk;

    led_pattern_gen #(.N_LEDS(4), .CLK_HZ(4), .TICK_HZ(1)) u_a (
        .hwclk(hwclk), .rst_n(rst_n), .en(en), .mode(mode), .leds(leds_a), .tick(tick_a));
    led_pattern_gen #(.N_LEDS(8), .CLK_HZ(24), .TICK_HZ(3)) u_b (
        .hwclk(hwclk), .rst_n(rst_n), .en(en), .mode(mode), .leds(leds_b), .tick(tick_b));
    led_pattern_gen #(.N_LEDS(4), .CLK_HZ(5), .TICK_HZ(5)) u_c (
        .hwclk(hwclk), .rst_n(rst_n), .en(en), .mode(mode), .leds(leds_c), .tick(tick_c));

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dut_leds(input int k);
        case (k)
            0:       return int'(leds_a);
            1:       return int'(leds_b);
            default: return int'(leds_c);
        endcase
    endfunction

    function automatic int dut_tick(input int k);
        case (k)
            0:       return int'(tick_a);
            1:       return int'(tick_b);
            default: return int'(tick_c);
        endcase
    endfunction

    function automatic int scan_value(input int n, input int phase);
        int pos;
        pos = (phase < n) ? phase : 2 * (n - 1) - phase;
        return 1 << pos;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_ecnt[k]  = 0;
            m_mode[k]  = 0;
            m_leds[k]  = 0;
            m_phase[k] = 0;
            m_tick[k]  = 0;
        end
    endtask

    // One rising edge of the reference model, using the inputs held over that edge.
    task automatic model_edge(input int k);
        int  n, mask;
        bit  stp;
        n    = m_n[k];
        mask = (1 << n) - 1;
        stp  = en && (m_ecnt[k] % m_div[k] == m_div[k] - 1);
        if (en) m_ecnt[k]++;
        m_tick[k] = int'(stp);
        if (!stp) return;
        if (int'(mode) != m_mode[k]) begin
            m_mode[k] = int'(mode);
            case (m_mode[k])
                0: m_leds[k] = 0;
                1: begin m_phase[k] = 0; m_leds[k] = 1; end
                2: m_leds[k] = mask;
                default: ;
            endcase
        end else begin
            case (m_mode[k])
                0: m_leds[k] = (m_leds[k] + 1) & mask;
                1: begin
                    m_phase[k] = (m_phase[k] + 1) % (2 * (n - 1));
                    m_leds[k]  = scan_value(n, m_phase[k]);
                end
                2: m_leds[k] = m_leds[k] ^ mask;
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string where);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("%s leds[%0d]", where, k), dut_leds(k), m_leds[k]);
            check($sformatf("%s tick[%0d]", where, k), dut_tick(k), m_tick[k]);
        end
    endtask

    task automatic run_cycle();
        @(posedge hwclk);
        if (rst_n)
            for (int k = 0; k < NDUT; k++) model_edge(k);
        @(negedge hwclk);
        check_all("cycle");
    endtask

    task automatic mid_cycle_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        @(negedge hwclk);
        check_all("rst_held");
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] m;
        int         len;
    } seg_t;

    seg_t segs[6] = '{
        '{2'd1, 140}, '{2'd0, 90}, '{2'd2, 40},
        '{2'd3, 40},  '{2'd0, 30}, '{2'd1, 60}
    };

    initial begin
        int stall;
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'd1;
        model_reset();
        repeat (3) @(negedge hwclk);
        check_all("reset");

        // Directed segments: SCAN taken at release, COUNT wrap, BLINK, HOLD, re-entry.
        rst_n = 1'b1;
        en    = 1'b1;
        foreach (segs[i]) begin
            mode = segs[i].m;
            repeat (segs[i].len) run_cycle();
        end

        // Enable stall of 10 cycles, then a reset between edges mid-period.
        repeat (3) run_cycle();
        en = 1'b0;
        repeat (10) run_cycle();
        en   = 1'b1;
        mode = 2'd0;
        repeat (13) run_cycle();
        mid_cycle_reset();
        repeat (20) run_cycle();

        stall = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 59) == 0)
                mode = 2'($urandom_range(0, 3));
            if (stall == 0 && $urandom_range(0, 39) == 0)
                stall = $urandom_range(1, 12);
            en = (stall == 0) || ($urandom_range(0, 7) == 0);
            if (stall > 0) stall--;
            if ($urandom_range(0, 299) == 0)
                mid_cycle_reset();
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern generator that drives an N-bit LED bank from the free-running board clock. A prescaler derives a tick of exact period from `CLK_HZ` and `TICK_HZ`. On each tick the bank advances one step of the selected pattern: binary count, bouncing scan, blink or hold. The block sits at the top level between `hwclk` and the LED pins and replaces single-purpose blinker counters.

## Interface
- `N_LEDS`, 8: width of the LED bank; legal values are ≥ 2.
- `CLK_HZ`, 12000000: `hwclk` frequency in Hz.
- `TICK_HZ`, 1: pattern step rate in Hz; `TICK_DIV = CLK_HZ / TICK_HZ`, truncated, must be ≥ 1.
- `hwclk` input, 1 bit: the single clock; all state is on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous assert, active-low.
- `en` input, 1 bit: prescaler run enable.
- `mode` input, 2 bits: pattern select. 0 = COUNT, 1 = SCAN, 2 = BLINK, 3 = HOLD.
- `leds` output, `N_LEDS` bits: LED drive, registered.
- `tick` output, 1 bit: one-cycle strobe, registered, high in the cycle where `leds` takes a stepped value.

## Operation
- Prescaler `pcnt`, width `$clog2(TICK_DIV)` (minimum 1 bit), counts 0..`TICK_DIV`-1 and then wraps to 0.
  - Period is exactly `TICK_DIV` cycles, with no +1 overshoot.
  - `en` = 0 freezes `pcnt` and suppresses steps.
- Step event: `step = en && pcnt == TICK_DIV-1`. All pattern state updates only on a step edge.
- Mode is sampled only at step; the registered copy is `mode_q`.
  - If `mode != mode_q` at step: `mode_q <= mode` and `leds <= seed(mode)`. No advance happens in that step.
  - Otherwise `leds` advances per `mode_q`.
- Seeds:
  - COUNT: 0.
  - SCAN: bit 0 set, direction up.
  - BLINK: all ones.
  - HOLD: current `leds` unchanged.
- Advance rules:
  - COUNT: `leds + 1`, modulo 2^`N_LEDS`; all ones wraps to 0.
  - SCAN: one-hot shift in the current direction. Reaching bit `N_LEDS`-1 flips direction to down; reaching bit 0 flips it to up. The end bit is shown for one step only; the sequence never repeats an end.
  - BLINK: `~leds`.
  - HOLD: no change.
- A non-one-hot `leds` can never occur in SCAN, because SCAN is entered only through its seed.
- Reset values: `pcnt` = 0, `leds` = 0, `mode_q` = COUNT, `dir` = up, `tick` = 0.
- Reset mid-operation clears everything asynchronously. The next step is `TICK_DIV` edges after release.

## Timing
- `tick` is registered from `step`: it is high for the one cycle following the step edge, coincident with the new `leds` value.
- Latency from `mode` change to visible effect: up to `TICK_DIV` cycles, taking effect at the next step edge.
- First step after `rst_n` rises is the `TICK_DIV`-th rising edge; `tick` follows in the next cycle.
- `TICK_DIV` = 1: step occurs every cycle while `en` = 1, and `tick` is held high continuously.
- `en` deasserted on the edge where `pcnt == TICK_DIV-1`: no step occurs; the step happens on the first enabled edge afterwards.
- Simultaneous mode change and step on the same edge: the new mode is taken at that step, and its seed is loaded on that edge.
- `leds` and `tick` are glitch-free; both are driven directly from flops.

## Structure
- Package `led_pkg`:
  - mode enum `led_mode_e` (COUNT, SCAN, BLINK, HOLD);
  - direction enum;
  - seed function taking `N_LEDS`.
- Sub-module `led_prescaler`:
  - parameter `DIV`;
  - ports `hwclk`, `rst_n`, `en`, `step`;
  - `step` is combinational from `pcnt`.
- The top holds `mode_q`, `dir`, `leds` and the `tick` flop.

## Test plan
- COUNT wrap, `N_LEDS`=4, `TICK_DIV`=4, `en`=1: `leds` goes 0, 1, 2 … 15, 0. `tick` pulses every 4th cycle, and each pulse coincides with a new value.
- SCAN bounce, `N_LEDS`=4, `TICK_DIV`=2: mode set at reset release; first step loads 0001. Then 0010, 0100, 1000, 0100, 0010, 0001, 0010, with no repeated end values.
- Mode change mid-period: COUNT at `leds`=5, `mode`←BLINK one cycle after a tick.
  - `leds` holds 5 until the next step, then shows 1111, 0000, 1111.
  - Switching to HOLD freezes the value while `tick` keeps pulsing.
- Enable stall, `TICK_DIV`=8: drop `en` for 10 cycles at `pcnt`=3. The next `tick` arrives exactly 10 cycles later than nominal, and `leds` is unchanged during the stall.
- Async reset: assert `rst_n`=0 between clock edges mid-period. `leds`=0 and `tick`=0 immediately, without a clock edge. After release, the first `tick` comes `TICK_DIV`+1 cycles later with `leds`=1 (COUNT).
- `TICK_DIV`=1 (`CLK_HZ`=`TICK_HZ`): COUNT increments every cycle and `tick` stays high continuously.
